// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue-side sequencer between FP decode and FP execute, producing registered
// writeback and fflags updates. Define FPU_ISSUE_TIMEOUT_EN to enable the multi-cycle watchdog.
module fpu_issue_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iss_valid,
    input  logic        iss_multi,
    input  logic        iss_fwren,
    input  logic        iss_wren,
    input  logic        iss_fflags_en,
    input  logic [4:0]  iss_waddr,
    input  logic        flush,
    output logic        iss_ready,
    output logic        exe_enable,
    input  logic        exe_ready,
    input  logic [31:0] exe_result,
    input  logic [4:0]  exe_fflags,
    output logic        wb_fwren,
    output logic        wb_wren,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        csr_fpunit,
    output logic [4:0]  csr_fflags,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        accept_s;
    logic        take_iss_s;
    logic        load_s;
    logic        expire_s;
    logic        timeout_s;

    logic        cap_fwren_r;
    logic        cap_wren_r;
    logic        cap_fflags_en_r;
    logic [4:0]  cap_waddr_r;

    logic        sel_fwren_s;
    logic        sel_wren_s;
    logic        sel_fflags_en_s;
    logic [4:0]  sel_waddr_s;

    logic        wb_fwren_r;
    logic        wb_wren_r;
    logic [4:0]  wb_waddr_r;
    logic [31:0] wb_wdata_r;
    logic        csr_fpunit_r;
    logic [4:0]  csr_fflags_r;

    // Integer writes to x0 are dropped; the FP file has no hardwired register.
    function automatic logic int_wr_en(input logic wren, input logic [4:0] waddr);
        return wren & (waddr != 5'd0);
    endfunction

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_r;

    // Watchdog counter: zero in IDLE, counts saturating while an op is outstanding.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= 8'd0;
        end else if ((state_r == WAIT) || (state_r == DRAIN)) begin
            if (cnt_r != 8'hFF) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= 8'd0;
        end
    end

    assign expire_s = (cnt_r == TO_LAST);
`else
    logic unused_timeout_s;

    assign unused_timeout_s = ^TIMEOUT;
    assign expire_s         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and handshake decode; exe_ready wins over flush and over watchdog expiry.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        take_iss_s  = 1'b0;
        load_s      = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (iss_valid && !flush && !reset) begin
                    accept_s = 1'b1;
                    if (iss_multi) begin
                        state_nxt_s = WAIT;
                    end else begin
                        take_iss_s  = 1'b1;
                        load_s      = exe_ready;
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (exe_ready) begin
                    load_s      = !flush;
                    state_nxt_s = IDLE;
                end else if (expire_s) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else if (flush) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DRAIN: begin
                if (exe_ready) begin
                    state_nxt_s = IDLE;
                end else if (expire_s) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Destination capture on every accepted instruction.
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_fwren_r     <= 1'b0;
            cap_wren_r      <= 1'b0;
            cap_fflags_en_r <= 1'b0;
            cap_waddr_r     <= 5'd0;
        end else if (accept_s) begin
            cap_fwren_r     <= iss_fwren;
            cap_wren_r      <= iss_wren;
            cap_fflags_en_r <= iss_fflags_en;
            cap_waddr_r     <= iss_waddr;
        end else begin
            cap_fwren_r     <= cap_fwren_r;
            cap_wren_r      <= cap_wren_r;
            cap_fflags_en_r <= cap_fflags_en_r;
            cap_waddr_r     <= cap_waddr_r;
        end
    end

    // Single-cycle ops complete in the accept cycle, before the capture registers update.
    always_comb begin
        sel_fwren_s     = cap_fwren_r;
        sel_wren_s      = cap_wren_r;
        sel_fflags_en_s = cap_fflags_en_r;
        sel_waddr_s     = cap_waddr_r;
        if (take_iss_s) begin
            sel_fwren_s     = iss_fwren;
            sel_wren_s      = iss_wren;
            sel_fflags_en_s = iss_fflags_en;
            sel_waddr_s     = iss_waddr;
        end else begin
            sel_fwren_s     = cap_fwren_r;
            sel_wren_s      = cap_wren_r;
            sel_fflags_en_s = cap_fflags_en_r;
            sel_waddr_s     = cap_waddr_r;
        end
    end

    // Writeback and CSR registers: strobes pulse for one cycle, payload holds between pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_fwren_r   <= 1'b0;
            wb_wren_r    <= 1'b0;
            wb_waddr_r   <= 5'd0;
            wb_wdata_r   <= 32'd0;
            csr_fpunit_r <= 1'b0;
            csr_fflags_r <= 5'd0;
        end else if (load_s) begin
            wb_fwren_r   <= sel_fwren_s;
            wb_wren_r    <= int_wr_en(sel_wren_s, sel_waddr_s);
            wb_waddr_r   <= sel_waddr_s;
            wb_wdata_r   <= exe_result;
            csr_fpunit_r <= sel_fflags_en_s;
            csr_fflags_r <= exe_fflags;
        end else begin
            wb_fwren_r   <= 1'b0;
            wb_wren_r    <= 1'b0;
            wb_waddr_r   <= wb_waddr_r;
            wb_wdata_r   <= wb_wdata_r;
            csr_fpunit_r <= 1'b0;
            csr_fflags_r <= csr_fflags_r;
        end
    end

    assign iss_ready  = accept_s;
    assign exe_enable = accept_s;
    assign busy       = (state_r != IDLE);
    assign timeout    = timeout_s & ~reset;
    assign wb_fwren   = wb_fwren_r;
    assign wb_wren    = wb_wren_r;
    assign wb_waddr   = wb_waddr_r;
    assign wb_wdata   = wb_wdata_r;
    assign csr_fpunit = csr_fpunit_r;
    assign csr_fflags = csr_fflags_r;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed-vector bench for fpu_issue_ctrl with hand-computed expectations.
// The watchdog scenario follows FPU_ISSUE_TIMEOUT_EN; without it the op must wait indefinitely.
module tb_fpu_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        iss_valid;
    logic        iss_multi;
    logic        iss_fwren;
    logic        iss_wren;
    logic        iss_fflags_en;
    logic [4:0]  iss_waddr;
    logic        flush;
    logic        iss_ready;
    logic        exe_enable;
    logic        exe_ready;
    logic [31:0] exe_result;
    logic [4:0]  exe_fflags;
    logic        wb_fwren;
    logic        wb_wren;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        csr_fpunit;
    logic [4:0]  csr_fflags;
    logic        busy;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    fpu_issue_ctrl #(.TIMEOUT(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .iss_valid     (iss_valid),
        .iss_multi     (iss_multi),
        .iss_fwren     (iss_fwren),
        .iss_wren      (iss_wren),
        .iss_fflags_en (iss_fflags_en),
        .iss_waddr     (iss_waddr),
        .flush         (flush),
        .iss_ready     (iss_ready),
        .exe_enable    (exe_enable),
        .exe_ready     (exe_ready),
        .exe_result    (exe_result),
        .exe_fflags    (exe_fflags),
        .wb_fwren      (wb_fwren),
        .wb_wren       (wb_wren),
        .wb_waddr      (wb_waddr),
        .wb_wdata      (wb_wdata),
        .csr_fpunit    (csr_fpunit),
        .csr_fflags    (csr_fflags),
        .busy          (busy),
        .timeout       (timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic issue(input logic v, input logic m, input logic fw, input logic w,
                         input logic fe, input logic [4:0] a);
        iss_valid     = v;
        iss_multi     = m;
        iss_fwren     = fw;
        iss_wren      = w;
        iss_fflags_en = fe;
        iss_waddr     = a;
    endtask

    task automatic exe(input logic r, input logic [31:0] res, input logic [4:0] ff);
        exe_ready  = r;
        exe_result = res;
        exe_fflags = ff;
    endtask

    task automatic idle_inputs();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        exe(1'b0, 32'd0, 5'd0);
        flush = 1'b0;
    endtask

    task automatic check_no_wb(input string tag);
        check_eq({tag, "_fwren"}, wb_fwren, 1'b0);
        check_eq({tag, "_wren"}, wb_wren, 1'b0);
        check_eq({tag, "_fpunit"}, csr_fpunit, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        mid();
        check_eq("rst_iss_ready", iss_ready, 1'b0);
        check_eq("rst_exe_enable", exe_enable, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_timeout", timeout, 1'b0);
        check_no_wb("rst");
        check_eq("rst_waddr", wb_waddr, 5'd0);
        check_eq("rst_wdata", wb_wdata, 32'd0);
        check_eq("rst_fflags", csr_fflags, 5'd0);
        tick();
        reset = 1'b0;

        // single-cycle fadd
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5);
        exe(1'b1, 32'h40400000, 5'h01);
        mid();
        check_eq("fadd_iss_ready", iss_ready, 1'b1);
        check_eq("fadd_exe_enable", exe_enable, 1'b1);
        check_eq("fadd_busy", busy, 1'b0);
        tick();
        idle_inputs();
        mid();
        check_eq("fadd_wb_fwren", wb_fwren, 1'b1);
        check_eq("fadd_wb_wren", wb_wren, 1'b0);
        check_eq("fadd_wb_waddr", wb_waddr, 5'd5);
        check_eq("fadd_wb_wdata", wb_wdata, 32'h40400000);
        check_eq("fadd_csr_fpunit", csr_fpunit, 1'b1);
        check_eq("fadd_csr_fflags", csr_fflags, 5'h01);
        check_eq("fadd_busy2", busy, 1'b0);
        tick();
        mid();
        check_no_wb("fadd_pulse");
        tick();

        // back-to-back singles, second writes f0
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7);
        exe(1'b1, 32'hAAAA0001, 5'h04);
        tick();
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        exe(1'b1, 32'hBBBB0002, 5'h00);
        mid();
        check_eq("b2b_iss_ready", iss_ready, 1'b1);
        check_eq("b2b_a_fwren", wb_fwren, 1'b1);
        check_eq("b2b_a_waddr", wb_waddr, 5'd7);
        check_eq("b2b_a_wdata", wb_wdata, 32'hAAAA0001);
        check_eq("b2b_a_fflags", csr_fflags, 5'h04);
        tick();
        idle_inputs();
        mid();
        check_eq("b2b_b_fwren", wb_fwren, 1'b1);
        check_eq("b2b_b_waddr", wb_waddr, 5'd0);
        check_eq("b2b_b_wdata", wb_wdata, 32'hBBBB0002);
        check_eq("b2b_b_fpunit", csr_fpunit, 1'b0);
        tick();

        // fdiv: accept at cycle 0, exe_ready at 10, held op accepted at 11
        issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9);
        mid();
        check_eq("fdiv_accept", iss_ready, 1'b1);
        tick();
        for (int c = 1; c <= 10; c++) begin
            issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3);
            if (c == 10) exe(1'b1, 32'h3F000000, 5'h02);
            else exe(1'b0, 32'h0, 5'h0);
            mid();
            check_eq("fdiv_busy", busy, 1'b1);
            check_eq("fdiv_iss_ready", iss_ready, 1'b0);
            check_eq("fdiv_exe_enable", exe_enable, 1'b0);
            check_eq("fdiv_no_wb", wb_fwren, 1'b0);
            tick();
        end
        exe(1'b1, 32'h22222222, 5'h00);
        mid();
        check_eq("fdiv_held_accept", iss_ready, 1'b1);
        check_eq("fdiv_busy_end", busy, 1'b0);
        check_eq("fdiv_wb_fwren", wb_fwren, 1'b1);
        check_eq("fdiv_wb_waddr", wb_waddr, 5'd9);
        check_eq("fdiv_wb_wdata", wb_wdata, 32'h3F000000);
        check_eq("fdiv_csr_fpunit", csr_fpunit, 1'b1);
        check_eq("fdiv_csr_fflags", csr_fflags, 5'h02);
        tick();
        idle_inputs();
        mid();
        check_eq("held_wb_waddr", wb_waddr, 5'd3);
        check_eq("held_wb_wdata", wb_wdata, 32'h22222222);
        check_eq("held_csr_fpunit", csr_fpunit, 1'b0);
        tick();

        // flush in WAIT at cycle 3, exe_ready at 8
        issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4);
        tick();
        for (int c = 1; c <= 8; c++) begin
            issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);
            flush = (c == 3);
            if (c == 8) exe(1'b1, 32'hDEADBEEF, 5'h1F);
            else exe(1'b0, 32'h0, 5'h0);
            mid();
            check_eq("drain_busy", busy, 1'b1);
            check_eq("drain_iss_ready", iss_ready, 1'b0);
            tick();
        end
        flush = 1'b0;
        exe(1'b1, 32'h0, 5'h0);
        mid();
        check_no_wb("drain_discard");
        check_eq("drain_iss_ready_after", iss_ready, 1'b1);
        check_eq("drain_busy_after", busy, 1'b0);
        tick();
        idle_inputs();
        tick();

        // flush and exe_ready together in WAIT: result discarded
        issue(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd12);
        tick();
        idle_inputs();
        flush = 1'b1;
        exe(1'b1, 32'h12345678, 5'h03);
        tick();
        idle_inputs();
        mid();
        check_no_wb("flush_ready");
        check_eq("flush_ready_busy", busy, 1'b0);
        tick();

        // flush in IDLE blocks acceptance
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2);
        exe(1'b1, 32'h55555555, 5'h01);
        flush = 1'b1;
        mid();
        check_eq("idle_flush_ready", iss_ready, 1'b0);
        tick();
        idle_inputs();
        mid();
        check_no_wb("idle_flush");
        tick();

        // fcmp to x0: integer write suppressed, fflags still updated
        issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        exe(1'b1, 32'h00000001, 5'h10);
        tick();
        idle_inputs();
        mid();
        check_eq("fcmp_wb_wren", wb_wren, 1'b0);
        check_eq("fcmp_wb_fwren", wb_fwren, 1'b0);
        check_eq("fcmp_csr_fpunit", csr_fpunit, 1'b1);
        check_eq("fcmp_csr_fflags", csr_fflags, 5'h10);
        tick();

        // fcvt to x7: integer write allowed
        issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7);
        exe(1'b1, 32'h0000002A, 5'h00);
        tick();
        idle_inputs();
        mid();
        check_eq("fcvt_wb_wren", wb_wren, 1'b1);
        check_eq("fcvt_wb_waddr", wb_waddr, 5'd7);
        check_eq("fcvt_wb_wdata", wb_wdata, 32'h0000002A);
        check_eq("fcvt_csr_fpunit", csr_fpunit, 1'b0);
        tick();

`ifdef FPU_ISSUE_TIMEOUT_EN
        // watchdog expiry with TIMEOUT=16
        issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6);
        tick();
        idle_inputs();
        for (int c = 1; c <= 17; c++) begin
            mid();
            check_eq("to_timeout", timeout, (c == 16) ? 1'b1 : 1'b0);
            check_eq("to_busy", busy, (c <= 16) ? 1'b1 : 1'b0);
            check_no_wb("to_wait");
            tick();
        end
        exe(1'b1, 32'h77777777, 5'h01);
        tick();
        idle_inputs();
        mid();
        check_no_wb("to_late_ready");
        check_eq("to_late_busy", busy, 1'b0);
        tick();

        // exe_ready on the expiry cycle completes normally
        issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8);
        tick();
        idle_inputs();
        for (int c = 1; c <= 16; c++) begin
            if (c == 16) exe(1'b1, 32'h66666666, 5'h08);
            else exe(1'b0, 32'h0, 5'h0);
            mid();
            check_eq("prio_timeout", timeout, 1'b0);
            tick();
        end
        idle_inputs();
        mid();
        check_eq("prio_wb_fwren", wb_fwren, 1'b1);
        check_eq("prio_wb_wdata", wb_wdata, 32'h66666666);
        check_eq("prio_wb_waddr", wb_waddr, 5'd8);
        tick();
`else
        // without the watchdog the op waits indefinitely
        issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6);
        tick();
        idle_inputs();
        for (int c = 1; c <= 40; c++) begin
            mid();
            check_eq("nowd_timeout", timeout, 1'b0);
            check_eq("nowd_busy", busy, 1'b1);
            tick();
        end
        exe(1'b1, 32'h66666666, 5'h08);
        tick();
        idle_inputs();
        mid();
        check_eq("nowd_wb_fwren", wb_fwren, 1'b1);
        check_eq("nowd_wb_wdata", wb_wdata, 32'h66666666);
        check_eq("nowd_wb_waddr", wb_waddr, 5'd6);
        check_eq("nowd_busy_end", busy, 1'b0);
        tick();
`endif

        // reset in WAIT cycle 4; exe_ready at 6 must be ignored
        issue(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd11);
        tick();
        idle_inputs();
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mid();
        check_eq("rst2_busy", busy, 1'b0);
        check_eq("rst2_iss_ready", iss_ready, 1'b0);
        check_eq("rst2_timeout", timeout, 1'b0);
        check_no_wb("rst2");
        check_eq("rst2_waddr", wb_waddr, 5'd0);
        check_eq("rst2_wdata", wb_wdata, 32'd0);
        check_eq("rst2_fflags", csr_fflags, 5'd0);
        tick();
        exe(1'b1, 32'hFFFFFFFF, 5'h1F);
        tick();
        idle_inputs();
        mid();
        check_no_wb("rst2_late");
        check_eq("rst2_late_busy", busy, 1'b0);
        check_eq("rst2_late_wdata", wb_wdata, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
